hp_mac_arbiter: RTL
===================

HP_MAC_ARBITER -- requirements
Module: hp_mac_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: max cycles waited in WAIT or DRAIN before an error response.
REQ-002 Parameter W, default 16: operand/result width (IEEE half precision), fixed at 16.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset83  in  1  reset, synchronous, active-low (0 = reset, sampled on rising clk).
REQ-005 r0_valid83 in 1 / r0_ready83 out 1 / r0_a83 in 16 / r0_b83 in 16: requester 0 operand-pair request.
REQ-006 r1_valid83 in 1 / r1_ready83 out 1 / r1_a83 in 16 / r1_b83 in 16: requester 1 operand-pair request.
REQ-007 s0_valid83 out 1 / s0_ready83 in 1 / s0_data83 out 16 / s0_err83 out 1: requester 0 response.
REQ-008 s1_valid83 out 1 / s1_ready83 in 1 / s1_data83 out 16 / s1_err83 out 1: requester 1 response.
REQ-009 core_start83 out 1 / core_a83 out 16 / core_b83 out 16: drive to shared halfPrecision core.
REQ-010 core_ans83 in 16 / core_done83 in 1: result and completion from core.
REQ-011 busy83  out  1  high in any state other than IDLE.

Function
REQ-012 FSM states IDLE, WAIT, DRAIN, RESP; exactly one core operation outstanding at any time.
REQ-013 IDLE: rX_ready83 high only for the requester selected by the round-robin picker; other ready low.
REQ-014 Picker: one valid requester -> that one; both valid -> the one not served last; after reset requester 0 has priority.
REQ-015 Accept on valid&ready in IDLE: latch a/b and requester id into holding registers, next state WAIT.
REQ-016 WAIT: core_start83 high; core_a83/core_b83 driven from holding registers, stable for the whole of WAIT.
REQ-017 WAIT: core_done83 sampled high -> latch core_ans83, err=0, next state DRAIN (core_start83 low from next cycle).
REQ-018 WAIT: TIMEOUT cycles elapsed without done -> err=1, data=16'h7E00 (qNaN), next state DRAIN.
REQ-019 DRAIN: core_start83 low; core_done83 low -> RESP; done still high after TIMEOUT cycles -> err=1, go RESP.
REQ-020 Cycle counter: clears on entry to WAIT and to DRAIN, saturates, never wraps.
REQ-021 RESP: sX_valid83 high for the latched requester only, with sX_data83/sX_err83 stable until sX_ready83.
REQ-022 RESP: valid&ready -> record served id for round robin, next state IDLE; no new accept in the same cycle.
REQ-023 Minimum latency with a 1-cycle core: accept T0, start T1, done sampled T1, DRAIN T2, response valid T3.
REQ-024 core_done83 high in IDLE is ignored; a request still waits for done low, enforced in DRAIN.
REQ-025 A requester that drops valid before ready is not accepted; a changed request in IDLE is re-arbitrated.
REQ-026 Outside IDLE, both rX_ready83 are low; outside RESP, both sX_valid83 are low.

Reset
REQ-027 reset83 low at a rising edge -> state IDLE, round-robin favours requester 0, counter 0, holding registers 0.
REQ-028 During reset all outputs are 0: ready, valid, err, data, core_start83, core operands, busy83.
REQ-029 Reset mid-operation (WAIT/DRAIN/RESP) abandons the operation without a response; core_start83 low the next cycle.

Structure
REQ-030 Package hp_mac_pkg holds the state enum, W, the qNaN constant 16'h7E00 and the TIMEOUT default.
REQ-031 One sub-module rr_arb2: two-way round-robin picker (inputs: two valids, last-served id; output: grant id).
REQ-032 The core is instantiated outside this block; this block holds no arithmetic.

Verification (core stub: done after N cycles, held until start low, ans = a XOR b)
REQ-033 r0 only, a=16'h3400 b=16'h3000, N=5 -> s0_valid83 with data 16'h0400, err 0; s1_valid83 never high.
REQ-034 r0 and r1 valid together, r1 a=16'h3A66 b=16'h3266 -> r0 served first, then r1 with data 16'h0800; then alternates.
REQ-035 Stub never asserts done, TIMEOUT=64 -> start high exactly 64 cycles, response data 16'h7E00, err 1.
REQ-036 s0_ready83 held low 10 cycles in RESP -> data stable; r1 not accepted until handshake completes.
REQ-037 reset83 low during WAIT -> next cycle core_start83 0, busy83 0, no response; a fresh r0 request completes normally.
REQ-038 Stub holds done 3 cycles after start drops -> response exactly after done falls; start not re-asserted meanwhile.

Source files
------------

// File: rtl/hp_mac_pkg.sv
// Shared types and constants for the half-precision core arbiter.
package hp_mac_pkg;

  localparam int HP_W = 16;
  localparam int TIMEOUT_DEFAULT = 64;
  localparam logic [HP_W-1:0] QNAN = 16'h7E00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone valid wins, a tie goes to the requester not served last.
module rr_arb2 (
  input  logic v0,
  input  logic v1,
  input  logic last,
  output logic grant
);

  always_comb begin
    grant = ~last;
    if (v0 && !v1) begin
      grant = 1'b0;
    end else if (v1 && !v0) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/hp_mac_arbiter.sv
// Shares one half-precision core between two requesters, one operation in flight at a time.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
module hp_mac_arbiter
  import hp_mac_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int W       = HP_W
) (
  input  logic         clk,
  input  logic         reset83,
  input  logic         r0_valid83,
  output logic         r0_ready83,
  input  logic [W-1:0] r0_a83,
  input  logic [W-1:0] r0_b83,
  input  logic         r1_valid83,
  output logic         r1_ready83,
  input  logic [W-1:0] r1_a83,
  input  logic [W-1:0] r1_b83,
  output logic         s0_valid83,
  input  logic         s0_ready83,
  output logic [W-1:0] s0_data83,
  output logic         s0_err83,
  output logic         s1_valid83,
  input  logic         s1_ready83,
  output logic [W-1:0] s1_data83,
  output logic         s1_err83,
  output logic         core_start83,
  output logic [W-1:0] core_a83,
  output logic [W-1:0] core_b83,
  input  logic [W-1:0] core_ans83,
  input  logic         core_done83,
  output logic         busy83,
  output state_t       dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  state_t         state;
  logic           last;
  logic           grant;
  logic           hold_id;
  logic [W-1:0]   hold_a;
  logic [W-1:0]   hold_b;
  logic [W-1:0]   res_data;
  logic           res_err;
  logic           start_q;
  logic           sv0;
  logic           sv1;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           resp_done;

  rr_arb2 u_rr (
    .v0    (r0_valid83),
    .v1    (r1_valid83),
    .last  (last),
    .grant (grant)
  );

  // Ready is gated by reset so nothing can be accepted while reset is held.
  assign r0_ready83 = reset83 && (state == ST_IDLE) && !grant;
  assign r1_ready83 = reset83 && (state == ST_IDLE) && grant;
  assign accept     = grant ? r1_valid83 : r0_valid83;
  assign resp_done  = (sv0 && s0_ready83) || (sv1 && s1_ready83);

  always_ff @(posedge clk) begin
    if (!reset83) begin
      state    <= ST_IDLE;
      last     <= 1'b1;
      hold_id  <= 1'b0;
      hold_a   <= '0;
      hold_b   <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
      start_q  <= 1'b0;
      sv0      <= 1'b0;
      sv1      <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            hold_id <= grant;
            hold_a  <= grant ? r1_a83 : r0_a83;
            hold_b  <= grant ? r1_b83 : r0_b83;
            start_q <= 1'b1;
            cnt     <= '0;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (core_done83) begin
            res_data <= core_ans83;
            res_err  <= 1'b0;
            start_q  <= 1'b0;
            cnt      <= '0;
            state    <= ST_DRAIN;
          end else if (cnt == CNT_LAST) begin
            res_data <= QNAN;
            res_err  <= 1'b1;
            start_q  <= 1'b0;
            cnt      <= '0;
            state    <= ST_DRAIN;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          // The core must release done before the next start can be issued.
          if (!core_done83 || cnt == CNT_LAST) begin
            if (core_done83) begin
              res_err <= 1'b1;
            end
            sv0   <= ~hold_id;
            sv1   <= hold_id;
            state <= ST_RESP;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_done) begin
            last  <= hold_id;
            sv0   <= 1'b0;
            sv1   <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s0_valid83   = sv0;
  assign s1_valid83   = sv1;
  assign s0_data83    = res_data;
  assign s1_data83    = res_data;
  assign s0_err83     = res_err;
  assign s1_err83     = res_err;
  assign core_start83 = start_q;
  assign core_a83     = hold_a;
  assign core_b83     = hold_b;
  assign busy83       = (state != ST_IDLE);
  assign dbg_state    = state;

endmodule
